ttc_tx_encoder: RTL

Serial TTC command-stream transmitter: the encoding end of the 160 Mb/s TTC link that the emulator's TTC receiver deframes. It accepts 16-bit command/trigger words over a valid/ready handshake and serialises them MSB-first, one bit per clock. It inserts the sync frame for receiver lock at start-up and periodically thereafter, and fills gaps with idle frames. It sits in test/DAQ-side firmware, and in loopback benches, driving an LVDS output buffer toward the emulator's `ttc_datap/ttc_datan` input.

---
 rtl/ttc_tx_encoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/ttc_tx_encoder.sv
// Serial TTC command-stream transmitter: sends 16-bit frames MSB-first, one bit per clock,
// with start-up and periodic sync frames and idle frames filling gaps in the traffic.
module ttc_tx_encoder #(
  parameter logic [15:0] SYNC_WORD     = 16'h817E,
  parameter logic [15:0] IDLE_WORD     = 16'h6969,
  parameter int unsigned N_INIT_SYNC   = 32,
  parameter int unsigned SYNC_INTERVAL = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] datain,
  input  logic        datain_valid,
  output logic        datain_ready,
  output logic        dataout,
  output logic        frame_start,
  output logic        sync_active,
  output logic        init_done
);

  localparam int unsigned InitW  = $clog2(N_INIT_SYNC + 1);
  localparam int unsigned SinceW = $clog2(SYNC_INTERVAL);

  localparam logic [InitW-1:0]  InitLoad = InitW'(N_INIT_SYNC);
  localparam logic [InitW-1:0]  InitOne  = InitW'(1);
  localparam logic [SinceW-1:0] SinceMax = SinceW'(SYNC_INTERVAL - 1);
  localparam logic [SinceW-1:0] SinceOne = SinceW'(1);

  typedef enum logic [1:0] {
    SelSync,
    SelData,
    SelIdle
  } frame_sel_e;

  logic [15:0]       shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [InitW-1:0]  init_cnt_q, init_cnt_d;
  logic [SinceW-1:0] since_sync_q, since_sync_d;
  logic              frame_start_q, frame_start_d;
  logic              sync_q, sync_d;

  logic       load;
  logic       sync_due;
  frame_sel_e sel;

  // Every 16th edge is a frame boundary; bit_cnt resets to 15 so edge 1 loads.
  assign load         = (bit_cnt_q == 4'd15);
  assign sync_due     = (init_cnt_q != '0) || (since_sync_q == SinceMax);
  assign datain_ready = load && !sync_due;

  always_comb begin
    sel = SelIdle;
    if (sync_due) begin
      sel = SelSync;
    end else if (datain_valid) begin
      sel = SelData;
    end
  end

  always_comb begin
    shreg_d       = {shreg_q[14:0], 1'b0};
    bit_cnt_d     = bit_cnt_q + 4'd1;
    init_cnt_d    = init_cnt_q;
    since_sync_d  = since_sync_q;
    frame_start_d = 1'b0;
    sync_d        = sync_q;
    if (load) begin
      frame_start_d = 1'b1;
      sync_d        = (sel == SelSync);
      unique case (sel)
        SelSync: begin
          shreg_d      = SYNC_WORD;
          since_sync_d = '0;
          if (init_cnt_q != '0) begin
            init_cnt_d = init_cnt_q - InitOne;
          end
        end
        SelData: begin
          shreg_d      = datain;
          since_sync_d = since_sync_q + SinceOne;
        end
        default: begin
          shreg_d      = IDLE_WORD;
          since_sync_d = since_sync_q + SinceOne;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q       <= '0;
      bit_cnt_q     <= 4'd15;
      init_cnt_q    <= InitLoad;
      since_sync_q  <= '0;
      frame_start_q <= 1'b0;
      sync_q        <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      init_cnt_q    <= init_cnt_d;
      since_sync_q  <= since_sync_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  assign dataout     = shreg_q[15];
  assign frame_start = frame_start_q;
  assign sync_active = sync_q;
  assign init_done   = (init_cnt_q == '0);

endmodule
